// File: rtl/regfile_pkg.sv
// regfile_pkg: sizing helpers shared by the multi-port register file
package regfile_pkg;
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction
    function automatic int slot(input int p, input int w);
        return p * w;
    endfunction
endpackage

// File: rtl/regfile_wr_sel.sv
// regfile_wr_sel: picks the highest-index enabled write port aimed at one target address
module regfile_wr_sel import regfile_pkg::*; #(
    parameter int WORD_SIZE = 32,
    parameter int AW        = 5,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic [AW-1:0]               target,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*WORD_SIZE-1:0] wr_data,
    output logic                        hit,
    output logic [WORD_SIZE-1:0]        data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i] && wr_addr[slot(i, AW) +: AW] == target && !(ZERO_REG != 0 && target == '0)) begin
                hit  = 1'b1;
                data = wr_data[slot(i, WORD_SIZE) +: WORD_SIZE];
            end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with same-cycle write bypass
// and a per-register busy scoreboard for issue/writeback tracking
module regfile_mp import regfile_pkg::*; #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW = clog2(NUM_REGS),
    localparam int CW = clog2(NUM_REGS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*AW-1:0]        rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*WORD_SIZE-1:0] wr_data,
    input  logic                        issue_en,
    input  logic [AW-1:0]               issue_rd,
    input  logic                        flush,
    output logic [CW-1:0]               busy_cnt
);
    logic [WORD_SIZE-1:0] regs   [NUM_REGS];
    logic [WORD_SIZE-1:0] w_data [NUM_REGS];
    logic [WORD_SIZE-1:0] r_data [NUM_RD];
    logic [NUM_REGS-1:0]  busy, busy_nx, w_hit;
    logic [NUM_RD-1:0]    r_hit;
    logic [CW-1:0]        cnt_nx;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_wsel
        regfile_wr_sel #(.WORD_SIZE(WORD_SIZE), .AW(AW), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)) u_sel (
            .target(AW'(g)), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
            .hit(w_hit[g]), .data(w_data[g])
        );
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rsel
        regfile_wr_sel #(.WORD_SIZE(WORD_SIZE), .AW(AW), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)) u_sel (
            .target(rd_addr[g*AW +: AW]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
            .hit(r_hit[g]), .data(r_data[g])
        );
    end

    // issue beats writeback so a new producer keeps ownership; flush beats both
    always_comb begin
        busy_nx = busy;
        cnt_nx  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_nx[r] = flush ? 1'b0
                       : (issue_en && issue_rd == AW'(r) && !(ZERO_REG != 0 && r == 0)) ? 1'b1
                       : w_hit[r] ? 1'b0 : busy[r];
            cnt_nx = cnt_nx + CW'(busy_nx[r]);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p*WORD_SIZE +: WORD_SIZE] = (ZERO_REG != 0 && rd_addr[p*AW +: AW] == '0) ? '0
                                              : (BYPASS != 0 && r_hit[p]) ? r_data[p]
                                              : regs[rd_addr[p*AW +: AW]];
            rd_busy[p] = (BYPASS != 0 && r_hit[p]) ? 1'b0 : busy[rd_addr[p*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (w_hit[r]) regs[r] <= w_data[r];
            busy     <= busy_nx;
            busy_cnt <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-based model
module tb_regfile_mp;
    localparam int W = 32, NR = 32, AW = 5, CW = 6, RD = 3, WR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] ra [RD];
    logic          we [WR];
    logic [AW-1:0] wa [WR];
    logic [W-1:0]  wd [WR];
    logic          iss_en, flush;
    logic [AW-1:0] iss_rd;

    logic [RD*AW-1:0] rd_addr;
    logic [RD*W-1:0]  rd_data;
    logic [RD-1:0]    rd_busy;
    logic [WR-1:0]    wr_en;
    logic [WR*AW-1:0] wr_addr;
    logic [WR*W-1:0]  wr_data;
    logic [CW-1:0]    busy_cnt;

    assign rd_addr = {ra[2], ra[1], ra[0]};
    assign wr_en   = {we[1], we[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    regfile_mp #(.WORD_SIZE(W), .NUM_REGS(NR), .NUM_RD(RD), .NUM_WR(WR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(iss_en), .issue_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    logic [AW-1:0] b_ra, b_wa;
    logic [W-1:0]  b_rd_data, b_wd;
    logic [0:0]    b_rd_busy, b_we;
    logic [CW-1:0] b_cnt;

    regfile_mp #(.WORD_SIZE(W), .NUM_REGS(NR), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(b_ra), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .issue_en(1'b0), .issue_rd(5'd0),
        .flush(1'b0), .busy_cnt(b_cnt)
    );

    logic [W-1:0] mem [NR];
    bit           mbusy [NR];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_data(input int p);
        logic [W-1:0] v;
        if (ra[p] == 0) return '0;
        v = mem[ra[p]];
        for (int i = 0; i < WR; i++) if (we[i] && wa[i] == ra[p]) v = wd[i];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_busy(input int p);
        for (int i = 0; i < WR; i++) if (we[i] && wa[i] == ra[p] && ra[p] != 0) return '0;
        return W'(mbusy[ra[p]]);
    endfunction

    function automatic logic [W-1:0] exp_cnt();
        int c = 0;
        for (int r = 0; r < NR; r++) c += int'(mbusy[r]);
        return W'(c);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin mem[r] = '0; mbusy[r] = 0; end
    endtask

    task automatic model_update();
        for (int i = 0; i < WR; i++) if (we[i] && wa[i] != 0) mem[wa[i]] = wd[i];
        if (flush) begin
            for (int r = 0; r < NR; r++) mbusy[r] = 0;
        end else begin
            for (int i = 0; i < WR; i++) if (we[i]) mbusy[wa[i]] = 0;
            if (iss_en && iss_rd != 0) mbusy[iss_rd] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < RD; p++) begin
            chk($sformatf("%s rd_data[%0d]", tag, p), rd_data[p*W +: W], exp_data(p));
            chk($sformatf("%s rd_busy[%0d]", tag, p), W'(rd_busy[p]), exp_busy(p));
        end
        chk($sformatf("%s busy_cnt", tag), W'(busy_cnt), exp_cnt());
    endtask

    task automatic clear();
        for (int i = 0; i < WR; i++) begin we[i] = 1'b0; wa[i] = '0; wd[i] = '0; end
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
        b_we = 1'b0; b_wa = '0; b_wd = '0;
    endtask

    task automatic settle();
        #5;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick(input string tag);
        settle();
        check_all(tag);
        edge_step();
    endtask

    initial begin
        clear();
        for (int p = 0; p < RD; p++) ra[p] = AW'(p);
        b_ra = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // random mixed traffic against the model
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < RD; p++) ra[p] = AW'($urandom_range(0, 31));
            for (int i = 0; i < WR; i++) begin
                we[i] = 1'($urandom_range(0, 1));
                wa[i] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
                wd[i] = $urandom;
            end
            iss_en = ($urandom_range(0, 2) == 0);
            iss_rd = AW'($urandom_range(0, 31));
            flush  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) ra[0] = wa[1];
            tick("rand");
        end

        // fill every register, then reset asynchronously mid-cycle
        clear();
        for (int r = 1; r < NR; r += 2) begin
            we[0] = 1'b1; wa[0] = AW'(r);     wd[0] = 32'h100 + r;
            we[1] = 1'b1; wa[1] = AW'(r + 1); wd[1] = 32'h200 + r;
            iss_en = 1'b1; iss_rd = AW'(r);
            tick("fill");
        end
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hDEAD;
        iss_en = 1'b1; iss_rd = 5'd12;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async reset busy_cnt", W'(busy_cnt), 32'd0);
        clear();
        #1;
        for (int p = 0; p < RD; p++) ra[p] = AW'(9 + p);
        #1;
        check_all("reset mid");
        @(posedge clk);
        #1;
        check_all("reset held");
        rst = 1'b1;

        // write port conflict on r5
        clear();
        ra[0] = 5'd5;
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hA;
        we[1] = 1'b1; wa[1] = 5'd5; wd[1] = 32'hB;
        settle();
        chk("conflict bypass", rd_data[0 +: W], 32'hB);
        check_all("conflict");
        edge_step();
        clear();
        settle();
        chk("conflict stored", rd_data[0 +: W], 32'hB);
        edge_step();

        // zero register
        ra[0] = 5'd0;
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_rd = 5'd0;
        settle();
        chk("zero bypass data", rd_data[0 +: W], 32'd0);
        chk("zero busy", W'(rd_busy[0]), 32'd0);
        edge_step();
        clear();
        settle();
        chk("zero stored", rd_data[0 +: W], 32'd0);
        chk("zero busy_cnt", W'(busy_cnt), 32'd0);
        edge_step();

        // issue then writeback r3
        iss_en = 1'b1; iss_rd = 5'd3; ra[1] = 5'd3;
        settle();
        edge_step();
        clear();
        settle();
        chk("issue r3 busy", W'(rd_busy[1]), 32'd1);
        chk("issue r3 cnt", W'(busy_cnt), 32'd1);
        edge_step();
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h33;
        settle();
        chk("wb r3 busy bypass", W'(rd_busy[1]), 32'd0);
        chk("wb r3 data bypass", rd_data[W +: W], 32'h33);
        edge_step();
        clear();
        settle();
        chk("wb r3 cnt", W'(busy_cnt), 32'd0);
        chk("wb r3 busy", W'(rd_busy[1]), 32'd0);
        edge_step();

        // issue and writeback r7 together, then flush against an issue of r8
        iss_en = 1'b1; iss_rd = 5'd7;
        we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h77;
        settle();
        edge_step();
        clear();
        ra[2] = 5'd7;
        settle();
        chk("iss+wb r7 busy", W'(rd_busy[2]), 32'd1);
        chk("iss+wb r7 cnt", W'(busy_cnt), 32'd1);
        chk("iss+wb r7 data", rd_data[2*W +: W], 32'h77);
        edge_step();
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd8;
        settle();
        edge_step();
        clear();
        ra[0] = 5'd8;
        settle();
        chk("flush cnt", W'(busy_cnt), 32'd0);
        chk("flush r8 busy", W'(rd_busy[0]), 32'd0);
        chk("flush r7 busy", W'(rd_busy[2]), 32'd0);
        check_all("flush");
        edge_step();

        // no-bypass build: same-cycle read sees the old value
        b_we = 1'b1; b_wa = 5'd4; b_wd = 32'h1111; b_ra = 5'd4;
        settle();
        edge_step();
        b_wd = 32'h1234;
        settle();
        chk("nobypass old", b_rd_data, 32'h1111);
        edge_step();
        b_we = 1'b0;
        settle();
        chk("nobypass new", b_rd_data, 32'h1234);
        chk("nobypass busy", W'(b_rd_busy), 32'd0);
        chk("nobypass cnt", W'(b_cnt), 32'd0);
        edge_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
